// File: rtl/soc_pkg.sv
// Shared SoC types and constants for the memory-mapped UART transmitter.
// Register map offsets, STATUS/CTRL bit positions and the TX FSM state type.
// Constants only; no timing or flow control of its own.
package soc_pkg;

  typedef enum logic [1:0] {
    UtxIdle,
    UtxStart,
    UtxData,
    UtxStop
  } UartTxState;

  localparam logic [1:0] UART_REG_DATA    = 2'd0;
  localparam logic [1:0] UART_REG_STATUS  = 2'd1;
  localparam logic [1:0] UART_REG_DIVISOR = 2'd2;
  localparam logic [1:0] UART_REG_CTRL    = 2'd3;

  localparam int UART_STAT_FULL      = 0;
  localparam int UART_STAT_EMPTY     = 1;
  localparam int UART_STAT_IDLE      = 2;
  localparam int UART_STAT_OVF       = 3;
  localparam int UART_STAT_HOLD      = 4;
  localparam int UART_STAT_COUNT_LSB = 8;

  localparam int UART_CTRL_IRQ_EN  = 0;
  localparam int UART_CTRL_OVF_CLR = 1;

  // A programmed divisor of 0 would never end a bit, so it runs as 1.
  function automatic logic [15:0] uart_eff_div(input logic [15:0] div);
    return (div == 16'd0) ? 16'd1 : div;
  endfunction

endpackage

// File: rtl/fifo_sync.sv
// Synchronous FIFO with combinational head read and wrap-bit full/empty decode.
// Latency: a push is visible at the head one clock later.
// Backpressure: push is accepted when not full, or when a pop happens on the same edge.
module fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign empty    = (wptr_q == rptr_q);
  assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count    = wptr_q - rptr_q;
  assign head_dat = mem_q[rptr_q[AW-1:0]];
  assign pop_ok   = pop & ~empty;
  assign push_ok  = push & (~full | pop_ok);

  always_comb begin
    wptr_d = wptr_q + {{AW{1'b0}}, push_ok};
    rptr_d = rptr_q + {{AW{1'b0}}, pop_ok};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wptr_q[AW-1:0]] <= push_dat;
    end
  end

endmodule

// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter: CPU bytes go through a FIFO to a serialiser on tx.
// Latency: reads return one clock after the strobe; a byte written idle starts its frame one clock later.
// Backpressure: a write to a full FIFO parks in a holding register and raises mem_wbusy until it drains.
module uart_tx_port
  import soc_pkg::*;
#(
  parameter int FIFO_DEPTH      = 8,
  parameter int DEFAULT_DIVISOR = 87
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic [1:0]  reg_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wmask,
  input  logic        mem_rstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_wbusy,
  output logic        mem_rbusy,
  output logic        tx,
  output logic        irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  UartTxState  state_q, state_d;
  logic [15:0] div_q, div_d;
  logic [15:0] bit_div_q, bit_div_d;
  logic [15:0] timer_q, timer_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        tx_q, tx_d;
  logic [7:0]  hold_dat_q, hold_dat_d;
  logic        hold_vld_q, hold_vld_d;
  logic        ovf_q, ovf_d;
  logic        irq_en_q, irq_en_d;
  logic [31:0] rdata_q, rdata_d;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_push_dat, fifo_head_dat;
  logic [CW-1:0] fifo_count;

  logic        wr_any, wr_data, wr_div, wr_ctrl, rd_en;
  logic        bit_end;
  logic [15:0] eff_div;
  logic [31:0] status;
  logic        unused_wdata;

  assign wr_any  = sel & (|mem_wmask);
  assign wr_data = wr_any & (reg_addr == UART_REG_DATA);
  assign wr_div  = wr_any & (reg_addr == UART_REG_DIVISOR);
  assign wr_ctrl = wr_any & (reg_addr == UART_REG_CTRL);
  assign rd_en   = sel & mem_rstrb;

  assign bit_end = (timer_q == 16'd0);
  assign eff_div = uart_eff_div(div_q);
  assign fifo_pop = ~fifo_empty &
                    ((state_q == UtxIdle) || ((state_q == UtxStop) && bit_end));

  assign unused_wdata = ^mem_wdata[31:16];

  fifo_sync #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .push    (fifo_push),
    .push_dat(fifo_push_dat),
    .pop     (fifo_pop),
    .head_dat(fifo_head_dat),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // The held byte waits for real room; it never rides along with a pop edge.
  always_comb begin
    hold_vld_d    = hold_vld_q;
    hold_dat_d    = hold_dat_q;
    ovf_d         = ovf_q;
    fifo_push     = 1'b0;
    fifo_push_dat = mem_wdata[7:0];
    if (wr_ctrl && mem_wdata[UART_CTRL_OVF_CLR]) begin
      ovf_d = 1'b0;
    end
    if (hold_vld_q) begin
      fifo_push_dat = hold_dat_q;
      if (!fifo_full) begin
        fifo_push  = 1'b1;
        hold_vld_d = 1'b0;
      end
      if (wr_data) begin
        ovf_d = 1'b1;
      end
    end else if (wr_data) begin
      if (!fifo_full || fifo_pop) begin
        fifo_push = 1'b1;
      end else begin
        hold_vld_d = 1'b1;
        hold_dat_d = mem_wdata[7:0];
      end
    end
  end

  always_comb begin
    status                                 = '0;
    status[UART_STAT_FULL]                 = fifo_full;
    status[UART_STAT_EMPTY]                = fifo_empty;
    status[UART_STAT_IDLE]                 = (state_q == UtxIdle);
    status[UART_STAT_OVF]                  = ovf_q;
    status[UART_STAT_HOLD]                 = hold_vld_q;
    status[UART_STAT_COUNT_LSB +: 8]       = 8'(fifo_count);
  end

  always_comb begin
    div_d    = div_q;
    irq_en_d = irq_en_q;
    rdata_d  = rdata_q;
    if (wr_div) begin
      div_d = mem_wdata[15:0];
    end
    if (wr_ctrl) begin
      irq_en_d = mem_wdata[UART_CTRL_IRQ_EN];
    end
    if (rd_en) begin
      case (reg_addr)
        UART_REG_STATUS:  rdata_d = status;
        UART_REG_DIVISOR: rdata_d = {16'd0, div_q};
        UART_REG_CTRL:    rdata_d = {31'd0, irq_en_q};
        default:          rdata_d = 32'd0;
      endcase
    end
  end

  // Bit timer counts D-1 down to 0; every state transition happens on its zero.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_div_d = bit_div_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    if ((state_q != UtxIdle) && !bit_end) begin
      timer_d = timer_q - 16'd1;
    end
    case (state_q)
      UtxIdle: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          state_d   = UtxStart;
          shreg_d   = fifo_head_dat;
          bit_div_d = eff_div;
          timer_d   = eff_div - 16'd1;
          tx_d      = 1'b0;
        end
      end
      UtxStart: begin
        if (bit_end) begin
          state_d   = UtxData;
          tx_d      = shreg_q[0];
          timer_d   = bit_div_q - 16'd1;
          bit_cnt_d = 3'd0;
        end
      end
      UtxData: begin
        if (bit_end) begin
          timer_d = bit_div_q - 16'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = UtxStop;
            tx_d    = 1'b1;
          end else begin
            shreg_d   = {1'b0, shreg_q[7:1]};
            tx_d      = shreg_q[1];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      UtxStop: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            state_d   = UtxStart;
            shreg_d   = fifo_head_dat;
            bit_div_d = eff_div;
            timer_d   = eff_div - 16'd1;
            tx_d      = 1'b0;
          end else begin
            state_d = UtxIdle;
          end
        end
      end
      default: begin
        state_d = UtxIdle;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= UtxIdle;
      div_q      <= 16'(DEFAULT_DIVISOR);
      bit_div_q  <= 16'(DEFAULT_DIVISOR);
      timer_q    <= 16'd0;
      shreg_q    <= 8'd0;
      bit_cnt_q  <= 3'd0;
      tx_q       <= 1'b1;
      hold_dat_q <= 8'd0;
      hold_vld_q <= 1'b0;
      ovf_q      <= 1'b0;
      irq_en_q   <= 1'b0;
      rdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_div_q  <= bit_div_d;
      timer_q    <= timer_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_q       <= tx_d;
      hold_dat_q <= hold_dat_d;
      hold_vld_q <= hold_vld_d;
      ovf_q      <= ovf_d;
      irq_en_q   <= irq_en_d;
      rdata_q    <= rdata_d;
    end
  end

  assign mem_rdata = rdata_q;
  assign mem_wbusy = hold_vld_q;
  assign mem_rbusy = 1'b0;
  assign tx        = tx_q;
  assign irq       = irq_en_q & fifo_empty & (state_q == UtxIdle) & ~hold_vld_q;

endmodule

// File: tb/tb_uart_tx_port.sv
// Scoreboard bench for uart_tx_port: stimulus queues expected frames and read data,
// independent monitors decode tx bit-by-bit and compare bus reads.
module tb_uart_tx_port;
  import soc_pkg::*;

  logic        clk       = 1'b0;
  logic        reset     = 1'b1;
  logic        sel       = 1'b0;
  logic [1:0]  reg_addr  = 2'd0;
  logic [31:0] mem_wdata = 32'd0;
  logic [3:0]  mem_wmask = 4'd0;
  logic        mem_rstrb = 1'b0;
  logic [31:0] mem_rdata;
  logic        mem_wbusy;
  logic        mem_rbusy;
  logic        tx;
  logic        irq;

  uart_tx_port #(
    .FIFO_DEPTH(8),
    .DEFAULT_DIVISOR(87)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .sel      (sel),
    .reg_addr (reg_addr),
    .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask),
    .mem_rstrb(mem_rstrb),
    .mem_rdata(mem_rdata),
    .mem_wbusy(mem_wbusy),
    .mem_rbusy(mem_rbusy),
    .tx       (tx),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] dat;
    int         div;
  } frame_t;

  typedef struct {
    string       name;
    logic [31:0] val;
  } rd_t;

  frame_t txq[$];
  rd_t    rdq[$];
  int     start_q[$];
  int     end_q[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  int     cyc      = 0;
  bit     mon_busy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  // Read monitor: one expected word per strobed read.
  rd_t rd_cur;
  always @(posedge clk) begin
    if (!reset && sel && mem_rstrb) begin
      #1;
      if (rdq.size() == 0) begin
        fail_now("read_unexpected");
      end else begin
        rd_cur = rdq.pop_front();
        check(rd_cur.name, mem_rdata, rd_cur.val);
      end
    end
  end

  // Serial monitor: every cycle of a frame must match the expected level.
  frame_t     fe;
  int         errs;
  int         bi;
  logic [7:0] got;
  logic       lvl;
  bit         aborted;
  always begin
    @(negedge clk);
    if (!reset && tx === 1'b0) begin
      if (txq.size() == 0) begin
        fail_now("frame_unexpected");
        while (tx === 1'b0 && !reset) @(negedge clk);
      end else begin
        fe       = txq.pop_front();
        mon_busy = 1'b1;
        errs     = 0;
        got      = 8'd0;
        aborted  = 1'b0;
        start_q.push_back(cyc);
        end_q.push_back(cyc + 10 * fe.div);
        for (int c = 0; c < 10 * fe.div; c++) begin
          if (c > 0) @(negedge clk);
          if (reset) begin
            aborted = 1'b1;
            break;
          end
          bi  = c / fe.div;
          lvl = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : fe.dat[bi-1];
          if (tx !== lvl) errs++;
          if (bi >= 1 && bi <= 8 && (c % fe.div) == fe.div / 2) got[bi-1] = tx;
        end
        if (!aborted) begin
          check("frame_byte", {24'd0, got}, {24'd0, fe.dat});
          check("frame_timing", 32'(errs), 32'd0);
        end
        mon_busy = 1'b0;
      end
    end
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    sel       = 1'b1;
    reg_addr  = a;
    mem_wdata = d;
    mem_wmask = 4'hF;
    @(negedge clk);
    sel       = 1'b0;
    mem_wmask = 4'h0;
  endtask

  task automatic bus_read(input string name, input logic [1:0] a, input logic [31:0] exp);
    rd_t r;
    @(negedge clk);
    sel       = 1'b1;
    reg_addr  = a;
    mem_rstrb = 1'b1;
    r.name    = name;
    r.val     = exp;
    rdq.push_back(r);
    @(negedge clk);
    sel       = 1'b0;
    mem_rstrb = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int d);
    frame_t f;
    f.dat = b;
    f.div = d;
    txq.push_back(f);
    bus_write(UART_REG_DATA, {24'd0, b});
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((txq.size() != 0 || mon_busy) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      fail_now(name);
      txq.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic clear_marks();
    start_q.delete();
    end_q.delete();
  endtask

  initial begin
    int n;
    int cyc_w;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_rdata", mem_rdata, 32'd0);
    check("rst_wbusy", 32'(mem_wbusy), 32'd0);
    check("rst_rbusy", 32'(mem_rbusy), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    bus_read("rst_status", UART_REG_STATUS, 32'h0000_0006);
    bus_read("rst_divisor", UART_REG_DIVISOR, 32'd87);
    bus_read("rst_ctrl", UART_REG_CTRL, 32'd0);

    // Single byte, D=4: start one clock after the write edge.
    bus_write(UART_REG_DIVISOR, 32'd4);
    send(8'hA5, 4);
    check("start_latency_pre", 32'(tx), 32'd1);
    @(negedge clk);
    check("start_latency", 32'(tx), 32'd0);
    drain("single_drain");
    bus_read("single_idle", UART_REG_STATUS, 32'h0000_0006);

    // Back-to-back frames, D=2.
    bus_write(UART_REG_DIVISOR, 32'd2);
    clear_marks();
    send(8'h00, 2);
    send(8'hFF, 2);
    drain("b2b_drain");
    if (start_q.size() < 2) fail_now("b2b_frames");
    else check("b2b_gap", 32'(start_q[1] - end_q[0]), 32'd0);

    // Backpressure: one byte in flight, then nine more.
    bus_write(UART_REG_DIVISOR, 32'd4);
    clear_marks();
    send(8'h11, 4);
    for (int i = 0; i < 8; i++) send(8'h20 + 8'(i), 4);
    check("bp_not_busy", 32'(mem_wbusy), 32'd0);
    send(8'h28, 4);
    check("bp_busy", 32'(mem_wbusy), 32'd1);
    bus_read("bp_status", UART_REG_STATUS, 32'h0000_0811);
    n = 0;
    while (mem_wbusy && n < 500) begin
      @(negedge clk);
      n++;
    end
    cyc_w = cyc;
    if (n >= 500 || start_q.size() < 2) fail_now("bp_release_wait");
    else check("bp_release", 32'(cyc_w - start_q[1]), 32'd1);
    drain("bp_drain");

    // Overflow: a DATA write while holding is dropped and flagged.
    send(8'h31, 4);
    for (int i = 0; i < 8; i++) send(8'h40 + 8'(i), 4);
    send(8'h48, 4);
    check("ovf_hold", 32'(mem_wbusy), 32'd1);
    bus_write(UART_REG_DATA, 32'h0000_0099);
    bus_read("ovf_status", UART_REG_STATUS, 32'h0000_0819);
    drain("ovf_drain");
    bus_read("ovf_sticky", UART_REG_STATUS, 32'h0000_000E);
    bus_write(UART_REG_CTRL, 32'h0000_0002);
    bus_read("ovf_cleared", UART_REG_STATUS, 32'h0000_0006);
    bus_read("ctrl_read", UART_REG_CTRL, 32'd0);

    // Divisor change mid-frame applies to the next frame only.
    send(8'h3C, 4);
    send(8'hC3, 8);
    bus_write(UART_REG_DIVISOR, 32'd8);
    bus_read("div_readback", UART_REG_DIVISOR, 32'd8);
    drain("div_drain");

    // IRQ on drain.
    bus_write(UART_REG_DIVISOR, 32'd2);
    bus_write(UART_REG_CTRL, 32'h0000_0001);
    check("irq_idle", 32'(irq), 32'd1);
    clear_marks();
    send(8'h5A, 2);
    check("irq_busy", 32'(irq), 32'd0);
    n = 0;
    while (!irq && n < 500) begin
      @(negedge clk);
      n++;
    end
    cyc_w = cyc;
    if (n >= 500 || end_q.size() < 1) fail_now("irq_wait");
    else check("irq_rise", 32'(cyc_w - end_q[0]), 32'd0);
    drain("irq_drain");

    // Reset mid-frame.
    send(8'h00, 2);
    repeat (8) @(negedge clk);
    check("mid_frame_low", 32'(tx), 32'd0);
    reset = 1'b1;
    #1;
    check("reset_tx", 32'(tx), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    txq.delete();
    @(negedge clk);
    check("reset_irq", 32'(irq), 32'd0);
    check("reset_wbusy", 32'(mem_wbusy), 32'd0);
    bus_read("reset_status", UART_REG_STATUS, 32'h0000_0006);
    bus_read("reset_divisor", UART_REG_DIVISOR, 32'd87);
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    fail_now("watchdog");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx_port.md
# uart_tx_port

Memory-mapped UART transmitter that responds on the SoC memory bus as an IO peripheral, alongside RAM and the LED port. The CPU writes bytes into a FIFO; an internal FSM serialises them 8N1, LSB first, on `tx`. It is the first IO responder that drives `mem_wbusy`: the bus stalls instead of dropping data when the FIFO is full. The SoC address decoder drives `sel` and routes `mem_rdata` back to the CPU.

## Interface
- `FIFO_DEPTH`, 8, number of FIFO entries; must be a power of 2, ≥2.
- `DEFAULT_DIVISOR`, 87, clocks per bit after reset (10 MHz / 115200).
- `clk`  in  1  system clock (PLL output, ~10 MHz).
- `reset`  in  1  one clock; reset is asynchronous and active-high.
- `sel`  in  1  address decoded to this peripheral.
- `reg_addr`  in  2  word offset: 0 DATA, 1 STATUS, 2 DIVISOR, 3 CTRL.
- `mem_wdata`  in  32  write data.
- `mem_wmask`  in  4  write strobe; any nonzero bit means a write.
- `mem_rstrb`  in  1  read strobe.
- `mem_rdata`  out  32  registered read data.
- `mem_wbusy`  out  1  write stall, registered.
- `mem_rbusy`  out  1  tied 0.
- `tx`  out  1  serial line, idle high.
- `irq`  out  1  level interrupt: TX drained.

## Operation
- Write to DATA (`sel & |mem_wmask & reg_addr==0`) captures `mem_wdata[7:0]`. If the FIFO is not full, or a pop happens on the same edge, the byte is pushed on that edge. Otherwise it goes into a 1-entry holding register and `hold_valid` is set.
- `mem_wbusy = hold_valid`. Each cycle the holding register pushes as soon as the FIFO has room, then clears `hold_valid`.
- A DATA write while `hold_valid=1` is a protocol violation. The byte is dropped and sticky `ovf` is set. `ovf` clears on a write to CTRL with bit 1 = 1.
- STATUS read, bits:
  - [0] full
  - [1] empty
  - [2] idle (FSM in IDLE)
  - [3] ovf
  - [4] hold_valid
  - [15:8] FIFO count
  - all other bits 0
- DIVISOR: bits [15:0] are R/W. The value is latched into the FSM only when a frame starts. A value of 0 is treated as 1.
- CTRL: bit 0 is `irq_en` (R/W). Bit 1 is write-1-to-clear for `ovf` and reads as 0.
- A DATA read returns 0.
- `irq = irq_en & empty & idle & ~hold_valid`.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE → START when the FIFO is non-empty: pop, load the shift register, latch the divisor D.
  - START → DATA after D cycles.
  - DATA → STOP after 8×D cycles, shifting LSB first, one bit per D cycles.
  - STOP → START if the FIFO is non-empty (pop; frames run back-to-back with no gap), else → IDLE. Transition after D cycles.
- Bit timer is a down-counter loaded with D−1; the bit ends when it reaches 0.
- FIFO pointers are log2(FIFO_DEPTH) bits plus 1 wrap bit. Full and empty are decoded from the wrap bit.

## Timing
- Reset values:
  - `tx`=1, `mem_rdata`=0, `mem_wbusy`=0, `irq`=0
  - FSM=IDLE, FIFO empty, `ovf`=0, `irq_en`=0
  - divisor=DEFAULT_DIVISOR
- Reset mid-frame aborts the frame immediately (`tx`=1) and flushes the FIFO and holding register.
- Read latency is 1: `mem_rdata` updates on the edge where `mem_rstrb & sel`; it holds its value otherwise.
- DATA write at edge N into an idle, empty block: the FSM pops at edge N+1 and `tx` falls after edge N+1. The frame is exactly 10×D cycles.
- Full FIFO write at edge N: `mem_wbusy`=1 after edge N. It stays 1 until the edge after the next pop, when the held byte enters the FIFO.
- Simultaneous push and pop on a full FIFO: both happen; count is unchanged.

## Structure
- `soc_pkg` holds:
  - `typedef enum logic [1:0] UartTxState {UtxIdle, UtxStart, UtxData, UtxStop}`
  - register offset constants: `UART_REG_DATA`/`STATUS`/`DIVISOR`/`CTRL`
  - STATUS bit index constants
- Sub-module `fifo_sync #(WIDTH, DEPTH)` provides push, pop, full, empty, count, with combinational read of the head entry.
- The SoC instantiates this block at IO word addresses 4–7.

## Test plan
- **Single byte:** divisor=4, write 0xA5 → `tx` low 4 clocks, then bits 1,0,1,0,0,1,0,1 for 4 clocks each, then high 4 clocks. 40 clocks total; `idle`=1 afterwards.
- **Back-to-back:** write 0x00, 0xFF with divisor=2 → two frames of 20 clocks with no idle gap; second start bit begins immediately after the first stop bit.
- **Backpressure:** write 9 bytes (depth 8) while the first is in flight → 9th write raises `mem_wbusy`. It drops the cycle after the first pop; all 9 bytes are transmitted in order.
- **Overflow:** with `hold_valid`=1, force another DATA write → STATUS bit 3 = 1 and the byte is never sent. CTRL write 0x2 → bit 3 = 0.
- **Divisor change mid-frame:** set D=8 during a D=4 frame → current frame stays 40 clocks, next frame is 80 clocks.
- **Reset and IRQ:** `irq_en`=1 with the FIFO draining → `irq` rises after the final stop bit. Assert `reset` mid-frame → `tx`=1 the same cycle, STATUS = 0x0000_0006 after release.
